bcd_up_counter: RTL

- Multi-digit BCD up-counter: the count-up counterpart to the team's single-digit BCD down-counter. Used for stopwatch, minute-counter and scoreboard displays.
- Counts in packed BCD from 0 up to a programmable limit, then wraps to 0.
- Gives a cascadable terminal-count strobe, synchronous clear, parallel load with BCD validity checking, and a sticky overflow flag.
- Feeds the seven-segment scan/decoder path directly.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_up.sv | 42 ++++
 rtl/bcd_up_counter.sv | 107 ++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions used by the up-counter, down-counter and display decoder.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [3:0]  BCD_MAX     = 4'd9;

  // A BCD digit is valid when it encodes 0..9.
  function automatic logic bcd_digit_valid(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

  // Invalid digits (10..15) are replaced by 0; valid digits pass through.
  function automatic logic [3:0] bcd_digit_sanitize(input logic [3:0] d);
    return bcd_digit_valid(d) ? d : '0;
  endfunction

endpackage

// File: rtl/bcd_digit_up.sv
// Single BCD digit up-count cell: clear > load > increment > hold.
module bcd_digit_up
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       carry_out
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next digit value; 9 rolls over to 0 so the digit never leaves 0..9.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = d;
    end else if (inc) begin
      q_d = (q_q == BCD_MAX) ? '0 : q_q + 4'd1;
    end
  end

  // Digit register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q         = q_q;
  assign carry_out = inc & (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_up_counter.sv
// Multi-digit packed-BCD up-counter with programmable limit, wrap to 0,
// cascadable terminal-count strobe, sticky overflow and load validity flag.
module bcd_up_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   limit,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  ovf,
  output logic                  load_err
);

  localparam int unsigned W = BCD_DIGIT_W * DIGITS;

  logic [W-1:0]      load_clean;
  logic [DIGITS-1:0] digit_bad;
  logic              at_limit;
  logic              wrap;
  logic              advance;
  logic              cell_clr;
  logic              cell_load;
  logic [DIGITS:0]   carry;

  logic ovf_q;
  logic ovf_d;
  logic load_err_q;
  logic load_err_d;

  // Sanitize the load value digit by digit and note which digits were invalid.
  always_comb begin
    load_clean = '0;
    digit_bad  = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      load_clean[BCD_DIGIT_W*i +: BCD_DIGIT_W] =
        bcd_digit_sanitize(load_val[BCD_DIGIT_W*i +: BCD_DIGIT_W]);
      digit_bad[i] = ~bcd_digit_valid(load_val[BCD_DIGIT_W*i +: BCD_DIGIT_W]);
    end
  end

  // Limit compare and the per-edge action decode (clr > load > en > hold).
  always_comb begin
    at_limit  = (count >= limit);
    wrap      = en & ~clr & ~load & at_limit;
    advance   = en & ~clr & ~load & ~at_limit;
    cell_clr  = clr | wrap;
    cell_load = load & ~clr;
  end

  assign tc       = wrap;
  assign carry[0] = advance;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_up u_digit (
        .clk       (clk),
        .rst       (rst),
        .inc       (carry[g]),
        .clr       (cell_clr),
        .load      (cell_load),
        .d         (load_clean[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
        .q         (count[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
        .carry_out (carry[g+1])
      );
    end
  endgenerate

  // Sticky overflow: set on any wrap, cleared only by clr or reset.
  // A carry out of the top digit can only occur if limit holds an invalid
  // digit above an all-9 count; the cells roll to 0 then, so flag it too.
  always_comb begin
    ovf_d = ovf_q;
    if (clr) begin
      ovf_d = 1'b0;
    end else if (wrap | carry[DIGITS]) begin
      ovf_d = 1'b1;
    end
  end

  // Load error is a single-cycle pulse following a load with a bad digit.
  always_comb begin
    load_err_d = ~clr & load & (|digit_bad);
  end

  // Status registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign ovf      = ovf_q;
  assign load_err = load_err_q;

endmodule
